// File: rtl/aer_event_packer.sv
// AER event packer: captures asynchronous DVS address events with a four-phase
// handshake, timestamps them, queues them in a FIFO and feeds them to a UART.
module aer_event_packer #(
    parameter int TICK_DIVIDE = 50,
    parameter int FIFO_AW     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               aer_req_n,
    input  logic [14:0]        aer_addr,
    output logic               aer_ack_n,
    input  logic               is_transmitting,
    output logic               transmit,
    output logic [31:0]        tx_word,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic [7:0]         drop_count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int PW    = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;

    localparam logic [PW-1:0]      PRE_MAX   = PW'(TICK_DIVIDE - 1);
    localparam logic [PW-1:0]      PRE_ONE   = PW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_EMPTY = (FIFO_AW + 1)'(0);

    typedef enum logic [1:0] {
        H_IDLE    = 2'd0,
        H_CAPTURE = 2'd1,
        H_ACK     = 2'd2,
        H_RELEASE = 2'd3
    } hs_state_t;

    typedef enum logic [1:0] {
        F_IDLE      = 2'd0,
        F_STROBE    = 2'd1,
        F_WAIT_BUSY = 2'd2,
        F_WAIT_DONE = 2'd3
    } feed_state_t;

    logic                sync1_r;
    logic                sync2_r;
    logic                req_sync_n_s;
    logic [PW-1:0]       pre_r;
    logic [15:0]         ts_r;
    hs_state_t           hs_state_r;
    hs_state_t           hs_next_s;
    feed_state_t         feed_state_r;
    feed_state_t         feed_next_s;
    logic                push_s;
    logic                pop_s;
    logic                wr_en_s;
    logic                drop_s;
    logic                full_s;
    logic                empty_s;
    logic [31:0]         word_s;
    logic [31:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_r;
    logic [FIFO_AW-1:0]  rd_ptr_r;
    logic [FIFO_AW:0]    level_r;
    logic                ack_n_r;
    logic                transmit_r;
    logic [31:0]         tx_word_r;
    logic                overflow_r;
    logic [7:0]          drop_cnt_r;

    // Two-flop synchronizer; idles high so reset never looks like a request
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= aer_req_n;
            sync2_r <= sync1_r;
        end
    end

    assign req_sync_n_s = sync2_r;

    // Prescaler and 16-bit timestamp, wrapping naturally at 0xFFFF
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
            ts_r  <= 16'h0000;
        end else if (pre_r == PRE_MAX) begin
            pre_r <= '0;
            ts_r  <= ts_r + 16'h0001;
        end else begin
            pre_r <= pre_r + PRE_ONE;
            ts_r  <= ts_r;
        end
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_state_r <= H_IDLE;
        end else begin
            hs_state_r <= hs_next_s;
        end
    end

    // Handshake next state; the single CAPTURE visit guarantees one push per event
    always_comb begin
        hs_next_s = hs_state_r;
        push_s    = 1'b0;
        case (hs_state_r)
            H_IDLE: begin
                if (!req_sync_n_s) begin
                    hs_next_s = H_CAPTURE;
                end else begin
                    hs_next_s = H_IDLE;
                end
            end
            H_CAPTURE: begin
                push_s    = 1'b1;
                hs_next_s = H_ACK;
            end
            H_ACK: begin
                if (req_sync_n_s) begin
                    hs_next_s = H_RELEASE;
                end else begin
                    hs_next_s = H_ACK;
                end
            end
            H_RELEASE: begin
                hs_next_s = H_IDLE;
            end
            default: begin
                hs_next_s = H_IDLE;
            end
        endcase
    end

    // Acknowledge is registered from the next state so it tracks H_ACK exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_n_r <= 1'b1;
        end else begin
            ack_n_r <= (hs_next_s != H_ACK);
        end
    end

    assign word_s  = {ts_r, 1'b0, aer_addr};
    assign full_s  = (level_r == LVL_FULL);
    assign empty_s = (level_r == LVL_EMPTY);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // FIFO storage; no reset needed because the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'h00;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) begin
                drop_cnt_r <= drop_cnt_r + 8'h01;
            end
        end
    end

    // Feeder state register
    always_ff @(posedge clk) begin
        if (rst) begin
            feed_state_r <= F_IDLE;
        end else begin
            feed_state_r <= feed_next_s;
        end
    end

    // Feeder next state; pops only from idle so strobes are at least four cycles apart
    always_comb begin
        feed_next_s = feed_state_r;
        pop_s       = 1'b0;
        case (feed_state_r)
            F_IDLE: begin
                if (!empty_s && !is_transmitting) begin
                    pop_s       = 1'b1;
                    feed_next_s = F_STROBE;
                end else begin
                    feed_next_s = F_IDLE;
                end
            end
            F_STROBE: begin
                feed_next_s = F_WAIT_BUSY;
            end
            F_WAIT_BUSY: begin
                if (is_transmitting) begin
                    feed_next_s = F_WAIT_DONE;
                end else begin
                    feed_next_s = F_WAIT_BUSY;
                end
            end
            F_WAIT_DONE: begin
                if (!is_transmitting) begin
                    feed_next_s = F_IDLE;
                end else begin
                    feed_next_s = F_WAIT_DONE;
                end
            end
            default: begin
                feed_next_s = F_IDLE;
            end
        endcase
    end

    // Strobe and word registers; tx_word holds the last popped word
    always_ff @(posedge clk) begin
        if (rst) begin
            transmit_r <= 1'b0;
            tx_word_r  <= 32'h0000_0000;
        end else begin
            transmit_r <= (feed_next_s == F_STROBE);
            if (pop_s) begin
                tx_word_r <= mem_r[rd_ptr_r];
            end else begin
                tx_word_r <= tx_word_r;
            end
        end
    end

    assign aer_ack_n  = ack_n_r;
    assign transmit   = transmit_r;
    assign tx_word    = tx_word_r;
    assign fifo_level = level_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_cnt_r;

endmodule

// File: tb/tb_aer_event_packer.sv
// Directed self-checking bench for aer_event_packer; one clock per timestamp tick
// so the 16-bit timestamp wrap is reachable in a short run.
module tb_aer_event_packer;

    localparam int TD = 1;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          aer_req_n;
    logic [14:0]   aer_addr;
    logic          aer_ack_n;
    logic          is_transmitting;
    logic          transmit;
    logic [31:0]   tx_word;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic [7:0]    drop_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            strobe_cnt = 0;
    int            busy_left = 0;
    logic          hold_busy = 1'b0;
    logic [15:0]   ts_model;
    logic [31:0]   rx_q [$];
    logic [31:0]   exp_q [$];

    aer_event_packer #(.TICK_DIVIDE(TD), .FIFO_AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .aer_req_n       (aer_req_n),
        .aer_addr        (aer_addr),
        .aer_ack_n       (aer_ack_n),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_word         (tx_word),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    // With one clock per tick the timestamp is the count of edges since reset
    always @(posedge clk) begin
        if (rst) ts_model <= 16'h0000;
        else     ts_model <= ts_model + 16'h0001;
    end

    // UART model: busy for three cycles after each strobe, or while held
    initial begin
        is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (transmit === 1'b1) begin
                rx_q.push_back(tx_word);
                strobe_cnt++;
                busy_left = 3;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            is_transmitting = hold_busy || (busy_left > 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_busy(input logic v);
        @(posedge clk);
        #1 hold_busy = v;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (aer_ack_n !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, aer_ack_n}, {31'd0, lvl});
    endtask

    task automatic hs_begin(input logic [14:0] addr, output logic [31:0] word);
        @(negedge clk);
        aer_addr  = addr;
        aer_req_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        word = {ts_model, 1'b0, addr};
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic hs_end();
        int lat = 0;
        @(negedge clk);
        aer_req_n = 1'b1;
        while (aer_ack_n !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("ack_rise_2to4", {31'd0, (lat >= 2 && lat <= 4)}, 32'd1);
    endtask

    task automatic send_event(input logic [14:0] addr, output logic [31:0] word);
        hs_begin(addr, word);
        hs_end();
    endtask

    task automatic expect_rx(input int n, input string tag);
        int waited = 0;
        while (rx_q.size() < n && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() > 0 && exp_q.size() > 0) check_eq(tag, rx_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] g;
        int guard;

        rst       = 1'b1;
        aer_req_n = 1'b1;
        aer_addr  = 15'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ack_n", {31'd0, aer_ack_n}, 32'd1);
        check_eq("rst_transmit", {31'd0, transmit}, 32'd0);
        check_eq("rst_tx_word", tx_word, 32'h0000_0000);
        check_eq("rst_level", {27'd0, fifo_level}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        check_eq("rst_drop", {24'd0, drop_count}, 32'd0);
        rst = 1'b0;

        // Single event at timestamp 5
        @(posedge clk);
        @(posedge clk);
        hs_begin(15'h1234, w);
        repeat (5) @(negedge clk);
        check_eq("ack_held_low", {31'd0, aer_ack_n}, 32'd0);
        hs_end();
        repeat (10) @(negedge clk);
        check_eq("single_strobe", strobe_cnt, 32'd1);
        check_eq("single_word", (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF, 32'h0005_1234);
        check_eq("tx_word_hold", tx_word, 32'h0005_1234);

        // Request held low for 100 cycles yields one push
        hs_begin(15'h7ABC, w);
        exp_q.push_back(w);
        repeat (100) @(negedge clk);
        check_eq("long_ack_low", {31'd0, aer_ack_n}, 32'd0);
        hs_end();
        repeat (20) @(negedge clk);
        expect_rx(1, "long_word");
        check_eq("long_one_strobe", strobe_cnt, 32'd2);
        check_eq("long_level", {27'd0, fifo_level}, 32'd0);

        // UART busy, 20 events into a 16-deep FIFO
        repeat (10) @(negedge clk);
        set_busy(1'b1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            send_event(15'h2000 | 15'(i), w);
            if (i < 16) exp_q.push_back(w);
        end
        check_eq("busy_level", {27'd0, fifo_level}, 32'd16);
        check_eq("busy_overflow", {31'd0, overflow}, 32'd1);
        check_eq("busy_drop", {24'd0, drop_count}, 32'd4);
        check_eq("busy_no_strobe", strobe_cnt, 32'd2);
        set_busy(1'b0);
        expect_rx(16, "order16");
        check_eq("drained_level", {27'd0, fifo_level}, 32'd0);

        // Refill, then push and pop in the same cycle on a full FIFO
        repeat (10) @(negedge clk);
        set_busy(1'b1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            send_event(15'h4000 | 15'(i), w);
            exp_q.push_back(w);
        end
        check_eq("refill_level", {27'd0, fifo_level}, 32'd16);
        @(negedge clk);
        aer_addr  = 15'h5A5A;
        aer_req_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        w = {ts_model, 1'b0, 15'h5A5A};
        hold_busy = 1'b0;
        exp_q.push_back(w);
        @(posedge clk);
        #1 hold_busy = 1'b1;
        check_eq("simul_level", {27'd0, fifo_level}, 32'd16);
        check_eq("simul_no_drop", {24'd0, drop_count}, 32'd4);
        wait_ack(1'b0, "simul_ack");
        hs_end();

        // Drop counter counts then saturates
        for (int i = 0; i < 100; i++) send_event(15'h6000 | 15'(i), w);
        check_eq("drop_104", {24'd0, drop_count}, 32'd104);
        for (int i = 0; i < 200; i++) send_event(15'h6100 | 15'(i), w);
        check_eq("drop_sat", {24'd0, drop_count}, 32'd255);
        check_eq("drop_level", {27'd0, fifo_level}, 32'd16);
        set_busy(1'b0);
        expect_rx(17, "order17");

        // Reset mid-handshake with three queued words
        repeat (10) @(negedge clk);
        set_busy(1'b1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) send_event(15'h0700 | 15'(i), w);
        check_eq("pre_rst_level", {27'd0, fifo_level}, 32'd3);
        hs_begin(15'h0F0F, w);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_ack_n", {31'd0, aer_ack_n}, 32'd1);
        check_eq("mid_rst_level", {27'd0, fifo_level}, 32'd0);
        check_eq("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        check_eq("mid_rst_drop", {24'd0, drop_count}, 32'd0);
        check_eq("mid_rst_tx_word", tx_word, 32'h0000_0000);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        w = {ts_model, 1'b0, 15'h0F0F};
        check_eq("recapture_ts3", w, 32'h0003_0F0F);
        exp_q.push_back(w);
        wait_ack(1'b0, "recapture_ack");
        check_eq("recapture_level", {27'd0, fifo_level}, 32'd1);
        hs_end();
        check_eq("rst_no_strobe", rx_q.size(), 32'd0);
        set_busy(1'b0);
        expect_rx(1, "recapture_word");

        // Timestamp wrap from 0xFFFF to 0x0000
        guard = 0;
        while (ts_model != 16'hFFFD && guard < 70000) begin
            @(posedge clk);
            #1 guard++;
        end
        check_eq("wrap_reached", {16'd0, ts_model}, 32'h0000_FFFD);
        send_event(15'h0055, w);
        guard = 0;
        while (rx_q.size() < 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        g = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
        check_eq("wrap_upper", {16'd0, g[31:16]}, 32'h0000_0000);
        check_eq("wrap_word", g, 32'h0000_0055);
        repeat (20) @(negedge clk);
        check_eq("total_strobes", strobe_cnt, 32'd37);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aer_event_packer.md
AER_EVENT_PACKER -- requirements
Module: aer_event_packer

Interface
REQ-001 Parameter TICK_DIVIDE, default 50: clk cycles per timestamp tick (1 us at 50 MHz).
REQ-002 Parameter FIFO_AW, default 4: FIFO address width; depth = 2**FIFO_AW entries.
REQ-003 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 clk  input  1  master clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 aer_req_n  input  1  asynchronous DVS request, active-low.
REQ-007 aer_addr  input  15  DVS address {y[6:0], x[6:0], polarity}, valid while aer_req_n low.
REQ-008 aer_ack_n  output  1  DVS acknowledge, active-low.
REQ-009 is_transmitting  input  1  UART busy flag.
REQ-010 transmit  output  1  one-cycle UART start strobe.
REQ-011 tx_word  output  32  word to the UART.
REQ-012 fifo_level  output  FIFO_AW+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky flag: at least one event dropped.
REQ-014 drop_count  output  8  dropped-event count, saturating at 255.

Function
REQ-015 aer_req_n SHALL pass through a 2-flop synchronizer; all handshake decisions use the synchronized value.
REQ-016 Handshake FSM states: H_IDLE, H_CAPTURE, H_ACK, H_RELEASE.
REQ-017 H_IDLE -> H_CAPTURE when synchronized req is low.
REQ-018 H_CAPTURE: latch aer_addr, form {timestamp[15:0], 1'b0, addr[14:0]}, push if not full, else drop; -> H_ACK, same cycle.
REQ-019 H_ACK: drive aer_ack_n low; -> H_RELEASE when synchronized req is high.
REQ-020 H_RELEASE: drive aer_ack_n high; -> H_IDLE. aer_ack_n is high in every other state.
REQ-021 Exactly one FIFO push per four-phase handshake, even if req stays low for many cycles.
REQ-022 Timestamp: 16-bit counter; prescaler counts 0..TICK_DIVIDE-1; timestamp increments on prescaler wrap; 0xFFFF wraps to 0x0000.
REQ-023 Drop (push while full): FIFO contents unchanged, overflow set to 1, drop_count incremented unless already 255.
REQ-024 Simultaneous push and pop on a full FIFO: the pop frees the entry, the push succeeds, and no drop is recorded.
REQ-025 Simultaneous push and pop at any level: fifo_level unchanged.
REQ-026 Feeder FSM states: F_IDLE, F_STROBE, F_WAIT_BUSY, F_WAIT_DONE.
REQ-027 F_IDLE -> F_STROBE when the FIFO is non-empty and is_transmitting is low; pop the head into the tx_word register.
REQ-028 F_STROBE: transmit = 1 for exactly one cycle; -> F_WAIT_BUSY.
REQ-029 F_WAIT_BUSY: -> F_WAIT_DONE when is_transmitting is high.
REQ-030 F_WAIT_DONE: -> F_IDLE when is_transmitting is low.
REQ-031 tx_word SHALL hold its value from the pop until the next pop.
REQ-032 Minimum spacing between transmit strobes is 4 cycles.
REQ-033 FIFO words are sent in push order, with no duplication or loss except drops.
REQ-034 fifo_level SHALL equal pushes minus pops, in the range 0..2**FIFO_AW.

Reset
REQ-035 On rst, the next clock edge SHALL set:
- aer_ack_n = 1, transmit = 0, tx_word = 0
- FIFO empty, fifo_level = 0
- overflow = 0, drop_count = 0
- timestamp = 0, prescaler = 0
- synchronizer flops = 1
- both FSMs to their idle state
REQ-036 rst during a handshake or transmission SHALL abort it: a held-low req is recaptured as a new event after reset; the word in flight in the UART is not re-sent.

Verification
REQ-037 Single event, addr=0x1234 at timestamp 0x0005, UART idle -> one transmit pulse; tx_word=0x00051234; aer_ack_n low until req rises.
REQ-038 req held low 100 cycles -> exactly one push; aer_ack_n rises 2-4 cycles after req release.
REQ-039 UART held busy, 20 events with FIFO_AW=4 -> fifo_level=16, overflow=1, drop_count=4; after busy releases, 16 words leave in order.
REQ-040 300 dropped events -> drop_count saturates at 255.
REQ-041 Timestamp at 0xFFFF plus 50 cycles -> event word upper half = 0x0000.
REQ-042 rst asserted mid-handshake with 3 queued words -> aer_ack_n=1, fifo_level=0, no transmit pulse; req still low -> new capture after reset.
